// File: rtl/vending_pkg.sv
// vending_pkg: shared state encoding, coin values and money width for the change dispenser.
package vending_pkg;
  localparam int MW = 8;
  localparam logic [MW-1:0] D5  = 8'd5;
  localparam logic [MW-1:0] D10 = 8'd10;
  localparam logic [MW-1:0] D20 = 8'd20;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    OFFER  = 3'd2,
    DONE   = 3'd3
  } state_t;
endpackage

// File: rtl/change_coin_select.sv
// change_coin_select: picks the largest in-stock coin not exceeding the remaining amount.
module change_coin_select
  import vending_pkg::*;
(
  input  logic [MW-1:0] remaining,
  input  logic [3:0]    stock_5,
  input  logic [3:0]    stock_10,
  input  logic [3:0]    stock_20,
  output logic          found,
  output logic [2:0]    sel
);
  logic t5, t10, t20;
  always_comb begin
    t20 = (remaining >= D20) && (|stock_20);
    t10 = (remaining >= D10) && (|stock_10);
    t5  = (remaining >= D5) && (|stock_5);
    sel = t20 ? 3'b100 : t10 ? 3'b010 : t5 ? 3'b001 : 3'b000;
    found = |sel;
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-by-coin change payout with a handshake to the coin mechanism.
module change_dispenser
  import vending_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          refund_all,
  input  logic [MW-1:0] sum_money,
  input  logic [MW-1:0] price,
  input  logic          coin_ack,
  input  logic          refill,
  input  logic [3:0]    refill_5,
  input  logic [3:0]    refill_10,
  input  logic [3:0]    refill_20,
  output logic          ready,
  output logic          coin_valid,
  output logic          deno_5,
  output logic          deno_10,
  output logic          deno_20,
  output logic          change_done,
  output logic          change_short,
  output logic [MW-1:0] short_amt,
  output logic [MW-1:0] paid_total,
  output logic [2:0]    state
);
  state_t        state_q, state_d;
  logic [MW-1:0] rem_q, rem_d, paid_q, paid_d, samt_q, samt_d, coin;
  logic          short_q, short_d, found, underpay;
  logic [2:0]    deno_q, deno_d, sel;
  logic [3:0]    s5_q, s5_d, s10_q, s10_d, s20_q, s20_d;

  change_coin_select u_sel (
    .remaining(rem_q),
    .stock_5  (s5_q),
    .stock_10 (s10_q),
    .stock_20 (s20_q),
    .found    (found),
    .sel      (sel)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    paid_d   = paid_q;
    samt_d   = samt_q;
    short_d  = short_q;
    deno_d   = deno_q;
    s5_d     = s5_q;
    s10_d    = s10_q;
    s20_d    = s20_q;
    underpay = !refund_all && (sum_money < price);
    coin     = deno_q[2] ? D20 : deno_q[1] ? D10 : D5;
    case (state_q)
      IDLE: begin
        s5_d  = refill ? refill_5 : s5_q;
        s10_d = refill ? refill_10 : s10_q;
        s20_d = refill ? refill_20 : s20_q;
        if (req) begin
          state_d = SELECT;
          rem_d   = underpay ? '0 : refund_all ? sum_money : sum_money - price;
          paid_d  = '0;
          samt_d  = '0;
          short_d = underpay;
        end
      end
      SELECT: begin
        state_d = found ? OFFER : DONE;
        deno_d  = found ? sel : deno_q;
        short_d = (!found && |rem_q) ? 1'b1 : short_q;
        samt_d  = (!found && |rem_q) ? rem_q : samt_q;
      end
      OFFER: begin
        if (coin_ack) begin
          state_d = SELECT;
          rem_d   = rem_q - coin;
          paid_d  = paid_q + coin;
          s5_d    = s5_q - {3'b0, deno_q[0] & (|s5_q)};
          s10_d   = s10_q - {3'b0, deno_q[1] & (|s10_q)};
          s20_d   = s20_q - {3'b0, deno_q[2] & (|s20_q)};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      paid_q  <= '0;
      samt_q  <= '0;
      short_q <= 1'b0;
      deno_q  <= '0;
      s5_q    <= '0;
      s10_q   <= '0;
      s20_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      paid_q  <= paid_d;
      samt_q  <= samt_d;
      short_q <= short_d;
      deno_q  <= deno_d;
      s5_q    <= s5_d;
      s10_q   <= s10_d;
      s20_q   <= s20_d;
    end
  end

  assign ready        = state_q == IDLE;
  assign coin_valid   = state_q == OFFER;
  assign {deno_20, deno_10, deno_5} = coin_valid ? deno_q : 3'b000;
  assign change_done  = state_q == DONE;
  assign change_short = short_q;
  assign short_amt    = samt_q;
  assign paid_total   = paid_q;
  assign state        = state_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized transactions checked against a greedy payout model.
module tb_change_dispenser;
  logic       clk = 1'b0;
  logic       reset, req, refund_all, coin_ack, refill;
  logic [7:0] sum_money, price;
  logic [3:0] refill_5, refill_10, refill_20;
  logic       ready, coin_valid, deno_5, deno_10, deno_20, change_done, change_short;
  logic [7:0] short_amt, paid_total;
  logic [2:0] state;
  int         checks = 0, fails = 0;
  int         st[3];

  typedef struct packed {
    logic [7:0]  n;
    logic [63:0] sig;
    logic [7:0]  paid;
    logic        sh;
    logic [7:0]  samt;
    logic [15:0] lat;
    logic        stable;
    logic        rdy;
    logic        to;
  } res_t;

  change_dispenser dut (
    .clk(clk), .reset(reset), .req(req), .refund_all(refund_all),
    .sum_money(sum_money), .price(price), .coin_ack(coin_ack), .refill(refill),
    .refill_5(refill_5), .refill_10(refill_10), .refill_20(refill_20),
    .ready(ready), .coin_valid(coin_valid), .deno_5(deno_5), .deno_10(deno_10),
    .deno_20(deno_20), .change_done(change_done), .change_short(change_short),
    .short_amt(short_amt), .paid_total(paid_total), .state(state)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic rf, input int sum, input int pr);
    res_t e;
    int   rem, d;
    e = '0;
    if (!rf && sum < pr) begin
      e.sh = 1'b1;
      return e;
    end
    rem = rf ? sum : sum - pr;
    for (int k = 0; k < 64; k++) begin
      d = (rem >= 20 && st[2] > 0) ? 20 : (rem >= 10 && st[1] > 0) ? 10 : (rem >= 5 && st[0] > 0) ? 5 : 0;
      if (d == 0) break;
      rem = rem - d;
      st[d == 20 ? 2 : d == 10 ? 1 : 0]--;
      e.paid = e.paid + 8'(d);
      e.n = e.n + 8'd1;
      e.sig = e.sig * 64'd37 + 64'(d);
    end
    e.sh = rem > 0;
    e.samt = 8'(rem);
    return e;
  endfunction

  task automatic do_refill(input int a, input int b, input int c);
    @(negedge clk);
    refill = 1'b1; refill_5 = 4'(a); refill_10 = 4'(b); refill_20 = 4'(c);
    @(negedge clk);
    refill = 1'b0;
    st = '{a, b, c};
  endtask

  task automatic drive_txn(input logic rf, input int sum, input int pr, input int dly,
                           input logic noise, input logic with_refill, output res_t o);
    int         dl;
    logic [2:0] dn;
    o = '0;
    o.stable = 1'b1;
    @(negedge clk);
    req = 1'b1; refund_all = rf; sum_money = 8'(sum); price = 8'(pr); refill = with_refill;
    @(negedge clk);
    req = 1'b0; refill = 1'b0; o.lat = 16'd1;
    while (!change_done && o.lat < 16'd2000) begin
      if (coin_valid) begin
        dn = {deno_20, deno_10, deno_5};
        if (!$onehot(dn)) o.stable = 1'b0;
        o.n = o.n + 8'd1;
        o.sig = o.sig * 64'd37 + (dn[2] ? 64'd20 : dn[1] ? 64'd10 : 64'd5);
        dl = dly < 0 ? int'($urandom_range(3, 0)) : dly;
        for (int i = 0; i < dl; i++) begin
          req = noise; refill = noise;
          if (noise) {refill_5, refill_10, refill_20} = 12'hFFF;
          @(negedge clk);
          o.lat = o.lat + 16'd1;
          if (!coin_valid || {deno_20, deno_10, deno_5} !== dn) o.stable = 1'b0;
        end
        req = 1'b0; refill = 1'b0; coin_ack = 1'b1;
        @(negedge clk);
        o.lat = o.lat + 16'd1;
        coin_ack = 1'b0;
      end else begin
        @(negedge clk);
        o.lat = o.lat + 16'd1;
      end
    end
    o.to = !change_done;
    o.paid = paid_total; o.sh = change_short; o.samt = short_amt;
    if (!o.to) @(negedge clk);
    o.rdy = ready;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, coin_valid, deno_5, deno_10, deno_20, change_done, change_short} !== 7'b1000000) begin
      fails++; $display("FAIL reset_flags: got %b want 1000000",
        {ready, coin_valid, deno_5, deno_10, deno_20, change_done, change_short});
    end
    checks++;
    if ({state, short_amt, paid_total} !== 19'd0) begin
      fails++; $display("FAIL reset_values: state %0d short %0d paid %0d want 0", state, short_amt, paid_total);
    end
    reset = 1'b0;
    st = '{0, 0, 0};
  endtask

  task automatic test_basic_change;
    res_t o, e;
    do_refill(4, 4, 4);
    e = model(1'b0, 35, 10);
    drive_txn(1'b0, 35, 10, 0, 1'b0, 1'b0, o);
    checks++;
    if (o.sig !== e.sig || o.n !== 8'd2 || o.to) begin
      fails++; $display("FAIL basic_coins: got n=%0d sig=%0d want n=2 sig=%0d", o.n, o.sig, e.sig);
    end
    checks++;
    if (o.paid !== 8'd25 || o.sh !== 1'b0) begin
      fails++; $display("FAIL basic_paid: got paid=%0d short=%0d want 25/0", o.paid, o.sh);
    end
  endtask

  task automatic test_exact;
    res_t o, e;
    e = model(1'b0, 20, 20);
    drive_txn(1'b0, 20, 20, 0, 1'b0, 1'b0, o);
    checks++;
    if (o.n !== 8'd0 || o.lat !== 16'd2 || o.sh !== 1'b0 || o.rdy !== 1'b1) begin
      fails++; $display("FAIL exact_latency: got n=%0d lat=%0d short=%0d rdy=%0d want 0/2/0/1",
        o.n, o.lat, o.sh, o.rdy);
    end
  endtask

  task automatic test_no_twenty;
    res_t o, e;
    do_refill(4, 4, 0);
    e = model(1'b0, 50, 10);
    drive_txn(1'b0, 50, 10, -1, 1'b0, 1'b0, o);
    checks++;
    if (o.sig !== e.sig || o.n !== 8'd4 || o.paid !== 8'd40) begin
      fails++; $display("FAIL no20_coins: got n=%0d paid=%0d want 4/40", o.n, o.paid);
    end
    e = model(1'b0, 10, 0);
    drive_txn(1'b0, 10, 0, 0, 1'b0, 1'b0, o);
    checks++;
    if (o.sig !== e.sig || o.n !== 8'd2) begin
      fails++; $display("FAIL no20_stock10_empty: got n=%0d sig=%0d want n=2 sig=%0d", o.n, o.sig, e.sig);
    end
  endtask

  task automatic test_short;
    res_t o, e;
    do_refill(4, 4, 4);
    e = model(1'b0, 17, 10);
    drive_txn(1'b0, 17, 10, 1, 1'b0, 1'b0, o);
    checks++;
    if (o.sig !== e.sig || o.n !== 8'd1 || o.sh !== 1'b1 || o.samt !== 8'd2) begin
      fails++; $display("FAIL short_17: got n=%0d short=%0d amt=%0d want 1/1/2", o.n, o.sh, o.samt);
    end
    e = model(1'b0, 5, 10);
    drive_txn(1'b0, 5, 10, 0, 1'b0, 1'b0, o);
    checks++;
    if (o.n !== 8'd0 || o.sh !== 1'b1 || o.samt !== 8'd0 || o.paid !== 8'd0) begin
      fails++; $display("FAIL underpay: got n=%0d short=%0d amt=%0d paid=%0d want 0/1/0/0",
        o.n, o.sh, o.samt, o.paid);
    end
  endtask

  task automatic test_refund_delay;
    res_t o, e;
    e = model(1'b1, 30, 25);
    drive_txn(1'b1, 30, 25, 3, 1'b1, 1'b0, o);
    checks++;
    if (o.sig !== e.sig || o.paid !== 8'd30 || o.sh !== 1'b0) begin
      fails++; $display("FAIL refund_coins: got n=%0d paid=%0d want n=2 paid=30", o.n, o.paid);
    end
    checks++;
    if (o.stable !== 1'b1) begin
      fails++; $display("FAIL refund_stable: got %0d want 1", o.stable);
    end
    e = model(1'b1, 40, 0);
    drive_txn(1'b1, 40, 0, 0, 1'b0, 1'b0, o);
    checks++;
    if (o.sig !== e.sig || o.paid !== e.paid || o.samt !== e.samt) begin
      fails++; $display("FAIL ignore_busy: got paid=%0d amt=%0d want paid=%0d amt=%0d",
        o.paid, o.samt, e.paid, e.samt);
    end
  endtask

  task automatic test_reset_offer;
    res_t o, e;
    do_refill(4, 4, 4);
    @(negedge clk);
    req = 1'b1; refund_all = 1'b1; sum_money = 8'd30; price = 8'd0;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 10 && !coin_valid; i++) @(negedge clk);
    checks++;
    if ({coin_valid, deno_20} !== 2'b11) begin
      fails++; $display("FAIL rst_offer_pre: got valid=%0d d20=%0d want 1/1", coin_valid, deno_20);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({state, coin_valid, ready, paid_total} !== {3'd0, 1'b0, 1'b1, 8'd0}) begin
      fails++; $display("FAIL rst_offer_post: state=%0d valid=%0d ready=%0d paid=%0d want 0/0/1/0",
        state, coin_valid, ready, paid_total);
    end
    st = '{0, 0, 0};
    e = model(1'b1, 15, 0);
    drive_txn(1'b1, 15, 0, 0, 1'b0, 1'b0, o);
    checks++;
    if (o.n !== e.n || o.sh !== e.sh || o.samt !== e.samt) begin
      fails++; $display("FAIL rst_stock_cleared: got n=%0d amt=%0d want n=%0d amt=%0d", o.n, o.samt, e.n, e.samt);
    end
  endtask

  task automatic test_refill_with_req;
    res_t o, e;
    refill_5 = 4'd1; refill_10 = 4'd0; refill_20 = 4'd2;
    st = '{1, 0, 2};
    e = model(1'b0, 60, 10);
    drive_txn(1'b0, 60, 10, 0, 1'b0, 1'b1, o);
    checks++;
    if (o.sig !== e.sig || o.paid !== 8'd45 || o.samt !== 8'd5) begin
      fails++; $display("FAIL refill_req: got paid=%0d amt=%0d want 45/5", o.paid, o.samt);
    end
  endtask

  task automatic test_random;
    res_t o, e;
    int   s, p;
    logic rf, wr;
    for (int it = 0; it < 30; it++) begin
      wr = 1'b0;
      if ($urandom_range(2, 0) == 0) begin
        if ($urandom_range(1, 0) == 1) begin
          do_refill(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
        end else begin
          refill_5 = 4'($urandom_range(15, 0)); refill_10 = 4'($urandom_range(15, 0));
          refill_20 = 4'($urandom_range(15, 0));
          st = '{int'(refill_5), int'(refill_10), int'(refill_20)};
          wr = 1'b1;
        end
      end
      rf = 1'($urandom_range(1, 0));
      s = int'($urandom_range(255, 0));
      p = ($urandom_range(4, 0) == 0) ? int'($urandom_range(255, 0)) : int'($urandom_range(s, 0));
      e = model(rf, s, p);
      drive_txn(rf, s, p, -1, 1'($urandom_range(1, 0)), wr, o);
      checks++;
      if (o.to || o.n !== e.n || o.sig !== e.sig) begin
        fails++; $display("FAIL rand_coins[%0d]: got n=%0d to=%0d want n=%0d", it, o.n, o.to, e.n);
      end
      checks++;
      if (o.paid !== e.paid || o.sh !== e.sh || o.samt !== e.samt) begin
        fails++; $display("FAIL rand_result[%0d]: got paid=%0d sh=%0d amt=%0d want %0d/%0d/%0d",
          it, o.paid, o.sh, o.samt, e.paid, e.sh, e.samt);
      end
      checks++;
      if (o.stable !== 1'b1 || o.rdy !== 1'b1) begin
        fails++; $display("FAIL rand_handshake[%0d]: got stable=%0d rdy=%0d want 1/1", it, o.stable, o.rdy);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; refund_all = 1'b0; coin_ack = 1'b0; refill = 1'b0;
    sum_money = '0; price = '0; refill_5 = '0; refill_10 = '0; refill_20 = '0;
    test_reset;
    test_basic_change;
    test_exact;
    test_no_twenty;
    test_short;
    test_refund_delay;
    test_reset_offer;
    test_refill_with_req;
    test_random;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
